// File: rtl/bsd_pkg.sv
// Shared types and helpers for the bit_stream_sync frame-sync detector.
// Holds the lock state encoding, the statistics counter width and a
// saturating increment used by the optional statistics counters.
`timescale 1ns/1ps
package bsd_pkg;

   typedef enum logic [1:0] {
      BSD_HUNT   = 2'd0,
      BSD_VERIFY = 2'd1,
      BSD_LOCKED = 2'd2
   } bsd_state_e;

   localparam int BSD_STAT_W = 16;

   function automatic logic [BSD_STAT_W-1:0] bsd_sat_inc(input logic [BSD_STAT_W-1:0] value);
      return (value == {BSD_STAT_W{1'b1}}) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/bsd_pattern_match.sv
// Serial pattern matcher for bit_stream_sync.
// Keeps the last PAT_W-1 valid bits and compares them, together with the
// incoming bit, against the masked sync word. A match is only reported once
// enough valid bits have arrived since reset/clr to fill the whole window.
`timescale 1ns/1ps
module bsd_pattern_match #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             din,
   input  logic             din_vld,
   input  logic [PAT_W-1:0] pat,
   input  logic [PAT_W-1:0] pat_mask,
   output logic             match
);

   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
   localparam logic [FILL_W-1:0] FILL_PREV = FILL_W'(PAT_W - 1);

   logic [PAT_W-2:0]  sr;
   logic [FILL_W-1:0] fill;
   logic [PAT_W-1:0]  window;
   logic              full;

   // The incoming bit completes the window, so only PAT_W-1 history bits are stored
   assign window = {sr, din};
   assign full   = (fill >= FILL_PREV);
   assign match  = din_vld & full & (((window ^ pat) & ~pat_mask) == '0);

   // Shift in each valid bit and count valid bits up to a full window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr   <= '0;
         fill <= '0;
      end else if (clr) begin
         sr   <= '0;
         fill <= '0;
      end else if (din_vld) begin
         sr <= window[PAT_W-2:0];
         if (fill != FILL_MAX) begin
            fill <= fill + 1'b1;
         end
      end
   end

endmodule

// File: rtl/bit_stream_sync.sv
// Serial frame-sync detector: hunts a maskable sync word, verifies it at
// FRAME_LEN-bit spacing, and holds lock until MISS_MAX consecutive misses.
// Optional statistics counters are enabled by defining BSD_STATS_EN.
`timescale 1ns/1ps
module bit_stream_sync
   import bsd_pkg::*;
#(
   parameter int PAT_W     = 4,
   parameter int FRAME_LEN = 16,
   parameter int LOCK_HITS = 3,
   parameter int MISS_MAX  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  din,
   input  logic                  din_vld,
   input  logic                  clr,
   input  logic [PAT_W-1:0]      pat,
   input  logic [PAT_W-1:0]      pat_mask,
`ifdef BSD_STATS_EN
   output logic [BSD_STAT_W-1:0] hit_cnt,
   output logic [BSD_STAT_W-1:0] loss_cnt,
`endif
   output logic                  lock,
   output logic [1:0]            state,
   output logic                  sync_pulse
);

   localparam int POS_W  = $clog2(FRAME_LEN);
   localparam int HITS_W = $clog2(LOCK_HITS + 1);
   localparam int MISS_W = $clog2(MISS_MAX + 1);

   localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_LEN - 1);
   localparam logic [HITS_W-1:0] HITS_LAST = HITS_W'(LOCK_HITS - 1);
   localparam logic [HITS_W-1:0] HITS_FULL = HITS_W'(LOCK_HITS);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

   bsd_state_e        state_q;
   logic [POS_W-1:0]  pos;
   logic [HITS_W-1:0] hits;
   logic [MISS_W-1:0] misses;
   logic              match;
   logic              checkpoint;
   logic              locked_hit;
   logic              loss_event;

   bsd_pattern_match #(
      .PAT_W (PAT_W)
   ) u_match (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .din      (din),
      .din_vld  (din_vld),
      .pat      (pat),
      .pat_mask (pat_mask),
      .match    (match)
   );

   assign checkpoint = din_vld & (pos == POS_LAST);
   assign locked_hit = ~clr & (state_q == BSD_LOCKED) & checkpoint & match;
   assign loss_event = ~clr & (state_q == BSD_LOCKED) & checkpoint & ~match & (misses == MISS_LAST);
   assign state      = state_q;

   // Lock state machine with frame position, hit and miss counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BSD_HUNT;
         lock       <= 1'b0;
         sync_pulse <= 1'b0;
         pos        <= '0;
         hits       <= '0;
         misses     <= '0;
      end else if (clr) begin
         state_q    <= BSD_HUNT;
         lock       <= 1'b0;
         sync_pulse <= 1'b0;
         pos        <= '0;
         hits       <= '0;
         misses     <= '0;
      end else begin
         sync_pulse <= 1'b0;
         if (din_vld) begin
            case (state_q)
               BSD_HUNT: begin
                  if (match) begin
                     pos  <= '0;
                     hits <= HITS_W'(1);
                     if (LOCK_HITS == 1) begin
                        state_q    <= BSD_LOCKED;
                        lock       <= 1'b1;
                        sync_pulse <= 1'b1;
                        misses     <= '0;
                     end else begin
                        state_q <= BSD_VERIFY;
                     end
                  end
               end
               BSD_VERIFY: begin
                  if (checkpoint) begin
                     pos <= '0;
                     if (match) begin
                        if (hits != HITS_FULL) begin
                           hits <= hits + 1'b1;
                        end
                        if (hits == HITS_LAST) begin
                           state_q    <= BSD_LOCKED;
                           lock       <= 1'b1;
                           sync_pulse <= 1'b1;
                           misses     <= '0;
                        end
                     end else begin
                        state_q <= BSD_HUNT;
                        hits    <= '0;
                     end
                  end else begin
                     pos <= pos + 1'b1;
                  end
               end
               BSD_LOCKED: begin
                  if (checkpoint) begin
                     pos <= '0;
                     if (locked_hit) begin
                        misses     <= '0;
                        sync_pulse <= 1'b1;
                     end else if (loss_event) begin
                        state_q <= BSD_HUNT;
                        lock    <= 1'b0;
                        hits    <= '0;
                        misses  <= '0;
                     end else begin
                        misses <= misses + 1'b1;
                     end
                  end else begin
                     pos <= pos + 1'b1;
                  end
               end
               default: begin
                  state_q <= BSD_HUNT;
                  lock    <= 1'b0;
                  hits    <= '0;
                  misses  <= '0;
               end
            endcase
         end
      end
   end

`ifdef BSD_STATS_EN
   // Saturating counts of locked checkpoint hits and of lock losses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         loss_cnt <= '0;
      end else if (clr) begin
         hit_cnt  <= '0;
         loss_cnt <= '0;
      end else begin
         if (locked_hit) begin
            hit_cnt <= bsd_sat_inc(hit_cnt);
         end
         if (loss_event) begin
            loss_cnt <= bsd_sat_inc(loss_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_bit_stream_sync.sv
// Testbench for bit_stream_sync (PAT_W=4, FRAME_LEN=8, LOCK_HITS=3, MISS_MAX=2).
// A behavioural model tracks valid-bit indices and the last sync anchor;
// directed scenarios plus a randomized phase are compared every cycle.
`timescale 1ns/1ps
module tb_bit_stream_sync;
   import bsd_pkg::*;

   localparam int PAT_W     = 4;
   localparam int FRAME_LEN = 8;
   localparam int LOCK_HITS = 3;
   localparam int MISS_MAX  = 2;

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b0;
   logic             din      = 1'b0;
   logic             din_vld  = 1'b0;
   logic             clr      = 1'b0;
   logic [PAT_W-1:0] pat      = 4'b1001;
   logic [PAT_W-1:0] pat_mask = 4'b0000;
   logic             lock;
   logic [1:0]       state;
   logic             sync_pulse;
`ifdef BSD_STATS_EN
   logic [BSD_STAT_W-1:0] hit_cnt;
   logic [BSD_STAT_W-1:0] loss_cnt;
`endif

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   // Behavioural reference state
   bit         hist[$];
   int         n_valid;
   int         anchor;
   int         m_hits;
   int         m_misses;
   bsd_state_e m_state;
   bit         m_lock;
   bit         m_pulse;

   always #5 clk = ~clk;

   bit_stream_sync #(
      .PAT_W     (PAT_W),
      .FRAME_LEN (FRAME_LEN),
      .LOCK_HITS (LOCK_HITS),
      .MISS_MAX  (MISS_MAX)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_vld    (din_vld),
      .clr        (clr),
      .pat        (pat),
      .pat_mask   (pat_mask),
`ifdef BSD_STATS_EN
      .hit_cnt    (hit_cnt),
      .loss_cnt   (loss_cnt),
`endif
      .lock       (lock),
      .state      (state),
      .sync_pulse (sync_pulse)
   );

   task automatic modelReset();
      hist.delete();
      n_valid  = 0;
      anchor   = 0;
      m_hits   = 0;
      m_misses = 0;
      m_state  = BSD_HUNT;
      m_lock   = 1'b0;
      m_pulse  = 1'b0;
   endtask

   // The last PAT_W valid bits, oldest first, must equal the word outside masked positions
   function automatic bit modelMatch();
      if (n_valid < PAT_W) return 1'b0;
      for (int i = 0; i < PAT_W; i++) begin
         if (!pat_mask[i] && (hist[hist.size() - 1 - i] != pat[i])) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Reference model: checkpoints are the valid bits FRAME_LEN after the last anchor
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || clr) begin
         modelReset();
      end else begin : model_step
         bit hit;
         bit cp;
         m_pulse = 1'b0;
         if (din_vld) begin
            hist.push_back(din);
            if (hist.size() > 32) void'(hist.pop_front());
            n_valid++;
            hit = modelMatch();
            cp  = ((n_valid - anchor) == FRAME_LEN);
            if (m_state == BSD_HUNT) begin
               if (hit) begin
                  anchor = n_valid;
                  m_hits = 1;
                  if (m_hits >= LOCK_HITS) begin
                     m_state = BSD_LOCKED; m_lock = 1'b1; m_pulse = 1'b1; m_misses = 0;
                  end else begin
                     m_state = BSD_VERIFY;
                  end
               end
            end else if (cp) begin
               anchor = n_valid;
               if (m_state == BSD_VERIFY) begin
                  if (hit) begin
                     m_hits++;
                     if (m_hits >= LOCK_HITS) begin
                        m_state = BSD_LOCKED; m_lock = 1'b1; m_pulse = 1'b1; m_misses = 0;
                     end
                  end else begin
                     m_state = BSD_HUNT; m_hits = 0;
                  end
               end else begin
                  if (hit) begin
                     m_misses = 0; m_pulse = 1'b1;
                  end else begin
                     m_misses++;
                     if (m_misses >= MISS_MAX) begin
                        m_state = BSD_HUNT; m_lock = 1'b0; m_hits = 0; m_misses = 0;
                     end
                  end
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle, compare the DUT against the model away from the clock edge
   always @(negedge clk) begin
      if (cmp_en) begin
         checkOutput("model_state", int'(state), int'(m_state));
         checkOutput("model_lock", int'(lock), int'(m_lock));
         checkOutput("model_pulse", int'(sync_pulse), int'(m_pulse));
      end
   end

   task automatic applyStimulus(input logic d, input logic v);
      din     = d;
      din_vld = v;
      @(negedge clk);
   endtask

   task automatic sendBit(input logic d, input int max_gap);
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
      applyStimulus(d, 1'b1);
   endtask

   task automatic sendWord(input logic [3:0] w, input int max_gap);
      for (int i = 3; i >= 0; i--) sendBit(w[i], max_gap);
   endtask

   task automatic restart(input logic [3:0] new_pat, input logic [3:0] new_mask);
      clr      = 1'b1;
      pat      = new_pat;
      pat_mask = new_mask;
      applyStimulus(1'b1, 1'b1);
      clr = 1'b0;
   endtask

   task automatic checkLiteral(input string name, input int exp_state, input int exp_lock);
      checkOutput({name, "_state"}, int'(state), exp_state);
      checkOutput({name, "_lock"}, int'(lock), exp_lock);
   endtask

   initial begin
      modelReset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      checkLiteral("reset", 0, 0);
      checkOutput("reset_pulse", int'(sync_pulse), 0);

      // Three spaced sync words lock on the third word's last bit
      sendWord(4'b1001, 0);
      checkLiteral("t1_first", 1, 0);
      sendWord(4'b0000, 0); sendWord(4'b1001, 0);
      checkLiteral("t1_second", 1, 0);
      sendWord(4'b0000, 0); sendWord(4'b1001, 0);
      checkLiteral("t1_locked", 2, 1);
      checkOutput("t1_pulse", int'(sync_pulse), 1);

      // One corrupted word keeps lock, two in a row drop it
      sendWord(4'b0000, 0); sendWord(4'b0001, 0);
      checkLiteral("t2_onemiss", 2, 1);
      checkOutput("t2_nopulse", int'(sync_pulse), 0);
      sendWord(4'b0000, 0); sendWord(4'b1001, 0);
      checkOutput("t2_rehit_pulse", int'(sync_pulse), 1);
      sendWord(4'b0000, 0); sendWord(4'b0001, 0);
      sendWord(4'b0000, 0); sendWord(4'b0001, 0);
      checkLiteral("t2_lost", 0, 0);

      // Gaps of invalid cycles do not change the outcome
      restart(4'b1001, 4'b0000);
      for (int f = 0; f < 2; f++) begin
         sendWord(4'b1001, 3); sendWord(4'b0000, 3);
      end
      sendWord(4'b1001, 3);
      checkLiteral("t3_locked", 2, 1);

      // Masked bit 2 makes 1101 match; unmasked it never matches
      restart(4'b1001, 4'b0100);
      for (int f = 0; f < 2; f++) begin
         sendWord(4'b1101, 0); sendWord(4'b0000, 0);
      end
      sendWord(4'b1101, 0);
      checkLiteral("t4_masked", 2, 1);
      restart(4'b1001, 4'b0000);
      for (int f = 0; f < 3; f++) begin
         sendWord(4'b1101, 0); sendWord(4'b0000, 0);
      end
      checkLiteral("t4_unmasked", 0, 0);

      // A VERIFY miss returns to HUNT and a new word restarts with one hit
      restart(4'b1001, 4'b0000);
      sendWord(4'b1001, 0); sendWord(4'b0000, 0); sendWord(4'b1101, 0);
      checkLiteral("t5_dropped", 0, 0);
      sendWord(4'b1001, 0);
      checkLiteral("t5_rehunt", 1, 0);
      sendWord(4'b0000, 0); sendWord(4'b1001, 0);
      checkLiteral("t5_two_hits", 1, 0);
      sendWord(4'b0000, 0); sendWord(4'b1001, 0);
      checkLiteral("t5_locked", 2, 1);

      // clr while locked, then async reset mid-word, then the fill guard
      restart(4'b1001, 4'b0000);
      checkLiteral("t6_clr", 0, 0);
      sendWord(4'b1001, 0); sendWord(4'b0000, 0); sendWord(4'b1001, 0);
      sendWord(4'b0000, 0); sendWord(4'b1001, 0);
      checkLiteral("t6_relocked", 2, 1);
      sendBit(1'b1, 0);
      #2 rst_n = 1'b0;
      #1 checkLiteral("t6_async", 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      sendBit(1'b1, 0); sendBit(1'b0, 0); sendBit(1'b0, 0);
      checkLiteral("t6_partial", 0, 0);
      sendBit(1'b1, 0);
      checkLiteral("t6_fill_match", 1, 0);
      restart(4'b0001, 4'b0000);
      sendBit(1'b0, 0); sendBit(1'b1, 0);
      checkLiteral("t6_fill_guard", 0, 0);
      sendWord(4'b0001, 0);
      checkLiteral("t6_after_fill", 1, 0);

      // Randomized frames with occasional corruption, gaps, mask changes and clears
      restart(4'b1001, 4'b0000);
      for (int f = 0; f < 250; f++) begin
         logic [3:0] w;
         if ($urandom_range(0, 59) == 0) restart(4'b1001, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0100);
         w = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1001;
         sendWord(w, ($urandom_range(0, 3) == 0) ? 2 : 0);
         sendWord(4'($urandom) & 4'($urandom), 0);
      end

      applyStimulus(1'b0, 1'b0);
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
